// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and
// the MEM/WB payload layout used by the first instantiating stage.
package pipe_stage_elastic_pkg;

    // Occupancy doubles as the stage state; there is no separate FSM register.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int MEMWB_W = 104;

    // MEM/WB field LSB offsets, lowest field first.
    localparam int MEMWB_RESSRC_LSB = 0;
    localparam int MEMWB_REGWR_LSB  = 2;
    localparam int MEMWB_PC4_LSB    = 3;
    localparam int MEMWB_RD_LSB     = 35;
    localparam int MEMWB_MEMRES_LSB = 40;
    localparam int MEMWB_ALU_LSB    = 72;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_res;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        reg_write;
        logic [1:0]  result_src;
    } memwb_t;

    function automatic logic [MEMWB_W-1:0] memwb_pack(input memwb_t f);
        return f;
    endfunction

    function automatic memwb_t memwb_unpack(input logic [MEMWB_W-1:0] v);
        return memwb_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One payload register plus its valid bit. Load, clear and drop are decoded
// by the parent; the data register only changes on a load or a clear.
module pipe_slot
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W   = MEMWB_W,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            if (CLR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // With CLR_DATA=0 reset leaves the payload stale; only the valid is cleared.
    always_ff @(posedge clk) begin
        if (reset_i && CLR_DATA) begin
            data_q <= '0;
        end else if (!reset_i) begin
            data_q <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main slot drives the output; with SKID=1 a second
// slot absorbs one beat so in_ready comes from a flop rather than out_ready.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W   = MEMWB_W,
    parameter bit SKID     = 1'b1,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int NSLOT = SKID ? 2 : 1;

    // Index 0 is the main (head) slot, index 1 the skid slot.
    logic [1:0]             slot_load;
    logic [1:0]             slot_drop;
    logic [1:0]             slot_valid;
    logic [1:0][DATA_W-1:0] slot_din;
    logic [1:0][DATA_W-1:0] slot_dout;

    logic accept;
    logic pop;

    assign accept    = in_valid & in_ready;
    assign pop       = slot_valid[0] & out_ready;
    assign out_valid = slot_valid[0];
    assign out_data  = slot_dout[0];
    assign occupancy = {1'b0, slot_valid[0]} + {1'b0, slot_valid[1]};

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            pipe_slot #(
                .DATA_W   (DATA_W),
                .CLR_DATA (CLR_DATA)
            ) u_slot (
                .clk     (clk),
                .reset_i (reset),
                .clear_i (flush),
                .load_i  (slot_load[gi]),
                .drop_i  (slot_drop[gi]),
                .data_i  (slot_din[gi]),
                .valid_o (slot_valid[gi]),
                .data_o  (slot_dout[gi])
            );
        end

        if (SKID) begin : g_skid_ctrl
            logic rdy_q, rdy_d;

            always_comb begin
                slot_load   = 2'b00;
                slot_drop   = 2'b00;
                slot_din[0] = in_data;
                slot_din[1] = in_data;
                rdy_d       = 1'b1;
                case (occupancy)
                    OCC_EMPTY: begin
                        slot_load[0] = accept;
                    end
                    OCC_ONE: begin
                        if (accept && pop) begin
                            slot_load[0] = 1'b1;
                        end else if (accept) begin
                            slot_load[1] = 1'b1;
                            rdy_d        = 1'b0;
                        end else if (pop) begin
                            slot_drop[0] = 1'b1;
                        end
                    end
                    OCC_FULL: begin
                        if (pop) begin
                            slot_din[0]  = slot_dout[1];
                            slot_load[0] = 1'b1;
                            slot_drop[1] = 1'b1;
                        end else begin
                            rdy_d = 1'b0;
                        end
                    end
                    default: begin
                        rdy_d = 1'b1;
                    end
                endcase
                if (flush) begin
                    rdy_d = 1'b1;
                end
            end

            // rdy_q tracks "skid empty next cycle"; it resets high and is masked
            // while reset is asserted so the stage opens the first cycle after.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= rdy_d;
                end
            end

            assign in_ready = rdy_q & ~reset;
        end else begin : g_single_ctrl
            always_comb begin
                slot_load    = 2'b00;
                slot_drop    = 2'b00;
                slot_din[0]  = in_data;
                slot_din[1]  = in_data;
                slot_load[0] = accept;
                slot_drop[0] = pop & ~accept;
            end

            assign slot_valid[1] = 1'b0;
            assign slot_dout[1]  = '0;
            assign in_ready      = (~slot_valid[0] | out_ready) & ~reset;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed vector tables for the SKID=1 and SKID=0 builds, plus a scoreboard
// stream through the skid build with random back-pressure.
module tb_pipe_stage_elastic;

    localparam int W = 104;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [W-1:0] id;
        logic         ord;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_occ;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst1, fl1, iv1, or1, ir1, ov1;
    logic [W-1:0] id1, od1;
    logic [1:0]   occ1;
    logic         rst0, fl0, iv0, or0, ir0, ov0;
    logic [W-1:0] id0, od0;
    logic [1:0]   occ0;

    int checks = 0;
    int passes = 0;

    pipe_stage_elastic #(.DATA_W(W), .SKID(1'b1), .CLR_DATA(1'b1)) dut_skid (
        .clk(clk), .reset(rst1), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_elastic #(.DATA_W(W), .SKID(1'b0), .CLR_DATA(1'b1)) dut_single (
        .clk(clk), .reset(rst0), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(occ0)
    );

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [W-1:0] id, input logic ord,
                                input logic e_ir, input logic e_ov,
                                input logic [W-1:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ord = ord;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic run_table(input int sel, input vec_t tab[$], input string tag);
        for (int i = 0; i < tab.size(); i++) begin
            if (sel == 1) begin
                rst1 = tab[i].rst; fl1 = tab[i].fl; iv1 = tab[i].iv;
                id1 = tab[i].id; or1 = tab[i].ord;
            end else begin
                rst0 = tab[i].rst; fl0 = tab[i].fl; iv0 = tab[i].iv;
                id0 = tab[i].id; or0 = tab[i].ord;
            end
            @(negedge clk);
            if (sel == 1) begin
                chk({tag, ".in_ready"},  i, W'(ir1),  W'(tab[i].e_ir));
                chk({tag, ".out_valid"}, i, W'(ov1),  W'(tab[i].e_ov));
                chk({tag, ".out_data"},  i, od1,      tab[i].e_od);
                chk({tag, ".occupancy"}, i, W'(occ1), W'(tab[i].e_occ));
            end else begin
                chk({tag, ".in_ready"},  i, W'(ir0),  W'(tab[i].e_ir));
                chk({tag, ".out_valid"}, i, W'(ov0),  W'(tab[i].e_ov));
                chk({tag, ".out_data"},  i, od0,      tab[i].e_od);
                chk({tag, ".occupancy"}, i, W'(occ0), W'(tab[i].e_occ));
            end
            $display("%s row %0d: rst=%0b fl=%0b iv=%0b id=%0h or=%0b -> ir/ov/od/occ checked",
                     tag, i, tab[i].rst, tab[i].fl, tab[i].iv, tab[i].id, tab[i].ord);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t t1[$];
        vec_t t0[$];
        logic [W-1:0] A, B, C, D, E, Z;
        logic [W-1:0] sb[$];
        logic [W-1:0] held;
        logic hold_prev;
        int sent, got;

        A = 'hA1; B = 'hB2; C = 'hC3; D = 'hD4; E = 'hE5; Z = '0;

        // SKID=1: reset, streaming, back-pressure, flush, flush+reset
        //            rst fl iv id ord  ir ov od occ
        t1.push_back(mk(1, 0, 1, A, 0,  0, 0, Z, 0));
        t1.push_back(mk(1, 0, 1, A, 0,  0, 0, Z, 0));
        t1.push_back(mk(1, 0, 1, A, 0,  0, 0, Z, 0));
        t1.push_back(mk(0, 0, 0, Z, 1,  1, 0, Z, 0));
        t1.push_back(mk(0, 0, 1, A, 1,  1, 0, Z, 0));
        t1.push_back(mk(0, 0, 1, B, 1,  1, 1, A, 1));
        t1.push_back(mk(0, 0, 1, C, 1,  1, 1, B, 1));
        t1.push_back(mk(0, 0, 0, Z, 1,  1, 1, C, 1));
        t1.push_back(mk(0, 0, 0, Z, 0,  1, 0, C, 0));
        t1.push_back(mk(0, 0, 1, A, 0,  1, 0, C, 0));
        t1.push_back(mk(0, 0, 1, B, 0,  1, 1, A, 1));
        t1.push_back(mk(0, 0, 1, C, 0,  0, 1, A, 2));
        t1.push_back(mk(0, 0, 1, C, 1,  0, 1, A, 2));
        t1.push_back(mk(0, 0, 1, C, 1,  1, 1, B, 1));
        t1.push_back(mk(0, 0, 0, Z, 1,  1, 1, C, 1));
        t1.push_back(mk(0, 0, 0, Z, 0,  1, 0, C, 0));
        t1.push_back(mk(0, 0, 1, A, 0,  1, 0, C, 0));
        t1.push_back(mk(0, 0, 1, B, 0,  1, 1, A, 1));
        t1.push_back(mk(0, 1, 1, D, 0,  0, 1, A, 2));
        t1.push_back(mk(0, 0, 0, Z, 1,  1, 0, Z, 0));
        t1.push_back(mk(0, 0, 1, D, 0,  1, 0, Z, 0));
        t1.push_back(mk(0, 1, 1, E, 1,  1, 1, D, 1));
        t1.push_back(mk(0, 0, 0, Z, 1,  1, 0, Z, 0));
        t1.push_back(mk(0, 0, 1, A, 0,  1, 0, Z, 0));
        t1.push_back(mk(1, 1, 1, B, 0,  0, 1, A, 1));
        t1.push_back(mk(0, 0, 0, Z, 0,  1, 0, Z, 0));

        // SKID=0: in_ready follows out_ready while full
        t0.push_back(mk(1, 0, 1, A, 0,  0, 0, Z, 0));
        t0.push_back(mk(0, 0, 1, A, 1,  1, 0, Z, 0));
        t0.push_back(mk(0, 0, 1, B, 1,  1, 1, A, 1));
        t0.push_back(mk(0, 0, 1, C, 0,  0, 1, B, 1));
        t0.push_back(mk(0, 0, 1, C, 1,  1, 1, B, 1));
        t0.push_back(mk(0, 0, 1, D, 0,  0, 1, C, 1));
        t0.push_back(mk(0, 0, 1, D, 1,  1, 1, C, 1));
        t0.push_back(mk(0, 0, 0, Z, 1,  1, 1, D, 1));
        t0.push_back(mk(0, 0, 0, Z, 0,  1, 0, D, 0));
        t0.push_back(mk(0, 1, 1, E, 0,  1, 0, D, 0));
        t0.push_back(mk(0, 0, 0, Z, 0,  1, 0, Z, 0));

        rst1 = 1; fl1 = 0; iv1 = 0; id1 = '0; or1 = 0;
        rst0 = 1; fl0 = 0; iv0 = 0; id0 = '0; or0 = 0;
        @(posedge clk);
        #1;

        run_table(1, t1, "skid");

        // Scoreboard stream with random back-pressure through the skid build.
        sent = 0; got = 0; hold_prev = 0; held = '0;
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            iv1 = (sent < 40) && ($urandom_range(0, 3) != 0);
            id1 = W'(32'h100 + sent);
            or1 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (hold_prev) begin
                chk("stream.stable", cyc, od1, held);
            end
            if (ov1 && or1) begin
                if (sb.size() == 0) begin
                    chk("stream.spurious", cyc, od1, 'x);
                end else begin
                    chk("stream.order", cyc, od1, sb.pop_front());
                    $display("stream cycle %0d: popped %0h", cyc, od1);
                end
                got++;
            end
            if (iv1 && ir1) begin
                sb.push_back(id1);
                sent++;
            end
            hold_prev = ov1 & ~or1;
            held = od1;
            @(posedge clk);
            #1;
        end
        chk("stream.count", 0, W'(got), W'(40));
        iv1 = 0; or1 = 0;

        rst0 = 1;
        run_table(0, t0, "single");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
